lcd_fill_sequencer: RTL and testbench
=====================================

// Module: lcd_fill_sequencer
// PURPOSE
//  Sequences the SPI LCD panel (ST7789-class, RGB565) for the Electric_Piano display path.
//  After reset it pulses the panel reset line, then streams the fixed init command list.
//  It then serves full-screen colour fill requests from the display-colour logic:
//  window set, then W*H pixels. One requester, req/ack handshake, one fill at a time.
// PARAMETERS
//  CLK_DIV       4       clk cycles per SCLK half-period (>=1)
//  RST_LOW_CYC   50000   cycles lcd_rst held low after reset release
//  RST_WAIT_CYC  6000000 wait cycles after lcd_rst rises, after SWRESET and after SLPOUT
//  LCD_W         240     panel width in pixels (1..65535)
//  LCD_H         240     panel height in pixels (1..65535)
// PORTS
//  clk         in   1   system clock (50 MHz)
//  rst         in   1   reset, asynchronous, active-high
//  fill_req    in   1   request full-screen fill; held until fill_ack
//  fill_color  in   16  RGB565 colour; sampled on the fill_ack cycle
//  fill_ack    out  1   1-cycle pulse: request accepted, colour latched
//  fill_done   out  1   1-cycle pulse: last pixel byte finished
//  busy        out  1   1 whenever the FSM is not IDLE
//  init_done   out  1   sticky 1 once the init list has completed
//  lcd_sclk    out  1   SPI clock, mode 0, idles low
//  lcd_mosi    out  1   SPI data, MSB first
//  lcd_cs      out  1   chip select, active-low
//  lcd_dc      out  1   0 = command byte, 1 = data byte
//  lcd_rst     out  1   panel reset, active-low
//  lcd_blk     out  1   backlight enable
// BEHAVIOUR
//  Reset values: sclk=0, mosi=0, cs=1, dc=0, lcd_rst=0, blk=0, busy=1, init_done=0, acks=0.
//  Reset is asynchronous, clk is the only clock. Reset mid-operation drops every output to its
//   reset value at once, discards any latched colour and count, and restarts at RST_LOW.
//  Byte engine, per byte (17*CLK_DIV cycles total):
//   - cs goes low and dc is set together, at the start of the byte.
//   - 8 bits MSB first. Per bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - mosi updates only on the first cycle of each low phase.
//   - After bit 0's high phase: sclk=0, cs=1 for a CLK_DIV-cycle gap, then the next byte or state.
//  FSM states:
//   - RST_LOW: RST_LOW_CYC cycles with lcd_rst=0 -> RST_WAIT.
//   - RST_WAIT: lcd_rst=1 for RST_WAIT_CYC cycles -> INIT.
//   - INIT: sends 01(C) [wait], 11(C) [wait], 3A(C) 55(D) 36(C) 00(D) 21(C) 29(C).
//     [wait] = RST_WAIT_CYC cycles after that byte's gap.
//     After the 29 gap: init_done=1, blk=1 -> IDLE.
//   - IDLE: busy=0. If fill_req=1: fill_ack pulse, latch fill_color, busy=1 next cycle -> WIN.
//   - WIN: sends 2A(C) 00 00 hi(W-1) lo(W-1) (D), 2B(C) 00 00 hi(H-1) lo(H-1) (D), 2C(C) -> PIX.
//   - PIX: LCD_W*LCD_H pixels, each colour[15:8] then colour[7:0], dc=1.
//     After the final gap: fill_done pulse, then IDLE the next cycle.
//  Pixel counter is sized clog2(LCD_W*LCD_H+1) and does not wrap before the terminal count.
//  Handshake and boundary rules:
//   - fill_req outside IDLE (init, WIN, PIX) is ignored: no ack, no queueing.
//   - The requester keeps fill_req high until busy falls.
//   - fill_color changes after ack have no effect on the fill in flight.
//   - fill_req already high when IDLE is entered is accepted on the first IDLE cycle.
//   - fill_done and fill_ack never assert in the same cycle.
// TESTING (CLK_DIV=2, RST_LOW_CYC=10, RST_WAIT_CYC=20, LCD_W=4, LCD_H=2)
//  Init: release rst -> lcd_rst low 10 cycles; then bytes 01,11,3A,55,36,00,21,29.
//   dc per byte = 0,0,0,1,0,1,0,0; init_done and blk rise after the 29 gap; busy falls.
//  Fill: fill_req=1 with colour F800 in IDLE -> ack 1 cycle.
//   Bytes: 2A 00 00 00 03 2B 00 00 00 01 2C, then 8x(F8 00) with dc=1; then one fill_done pulse.
//  Timing: each byte = 34 clk cycles; mosi stable at every sclk rising edge; cs high 2 cycles between bytes.
//  Ignore: fill_req pulsed during INIT and again during PIX -> no fill_ack, pixel count unchanged.
//   Colour changed to 07E0 mid-PIX -> all 8 pixels still F8 00.
//  Reset mid-PIX: rst high on a pixel bit -> same cycle cs=1, sclk=0, lcd_rst=0, init_done=0, busy=1.
//   After release the full init sequence repeats.

Source files
------------

// File: rtl/lcd_fill_sequencer.sv
// SPI LCD sequencer (ST7789-class, RGB565): panel reset pulse, fixed init command
// list, then full-screen colour fills served one at a time over a req/ack handshake.
module lcd_fill_sequencer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RST_LOW_CYC  = 50000,
  parameter int unsigned RST_WAIT_CYC = 6000000,
  parameter int unsigned LCD_W        = 240,
  parameter int unsigned LCD_H        = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_req,
  input  logic [15:0] fill_color,
  output logic        fill_ack,
  output logic        fill_done,
  output logic        busy,
  output logic        init_done,
  output logic        lcd_sclk,
  output logic        lcd_mosi,
  output logic        lcd_cs,
  output logic        lcd_dc,
  output logic        lcd_rst,
  output logic        lcd_blk
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PIX_TOT = LCD_W * LCD_H;
  localparam int unsigned PIX_W   = $clog2(PIX_TOT + 1);
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned PH_W    = 5;
  localparam logic [15:0] W_MAX   = 16'(LCD_W - 1);
  localparam logic [15:0] H_MAX   = 16'(LCD_H - 1);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT,
    S_IDLE,
    S_WIN,
    S_PIX,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               waiting;
  logic [15:0]        color;
  logic [PIX_W-1:0]   pix_cnt;
  logic               pix_lo;

  logic               eng_active;
  logic [PH_W-1:0]    phase;
  logic [DIV_W-1:0]   div;
  logic [7:0]         shreg;

  logic               start;
  logic [8:0]         tx_word;
  logic               eng_last;
  logic               wait_done;
  logic               wait_after;

  // Init command list as {dc, byte}
  function automatic logic [8:0] init_rom(input logic [IDX_W-1:0] i);
    case (i)
      4'd0:    init_rom = {1'b0, 8'h01};
      4'd1:    init_rom = {1'b0, 8'h11};
      4'd2:    init_rom = {1'b0, 8'h3A};
      4'd3:    init_rom = {1'b1, 8'h55};
      4'd4:    init_rom = {1'b0, 8'h36};
      4'd5:    init_rom = {1'b1, 8'h00};
      4'd6:    init_rom = {1'b0, 8'h21};
      4'd7:    init_rom = {1'b0, 8'h29};
      default: init_rom = {1'b0, 8'h00};
    endcase
  endfunction

  // Full-screen window set (CASET, RASET, RAMWR) as {dc, byte}
  function automatic logic [8:0] win_rom(input logic [IDX_W-1:0] i);
    case (i)
      4'd0:                   win_rom = {1'b0, 8'h2A};
      4'd1, 4'd2, 4'd6, 4'd7: win_rom = {1'b1, 8'h00};
      4'd3:                   win_rom = {1'b1, W_MAX[15:8]};
      4'd4:                   win_rom = {1'b1, W_MAX[7:0]};
      4'd5:                   win_rom = {1'b0, 8'h2B};
      4'd8:                   win_rom = {1'b1, H_MAX[15:8]};
      4'd9:                   win_rom = {1'b1, H_MAX[7:0]};
      default:                win_rom = {1'b0, 8'h2C};
    endcase
  endfunction

  assign eng_last   = eng_active && (phase == PH_W'(16)) && (div == DIV_W'(CLK_DIV - 1));
  assign wait_done  = (cnt == CNT_W'(RST_WAIT_CYC - 1));
  assign wait_after = (idx == IDX_W'(1)) || (idx == IDX_W'(2));

  // Next byte to launch; a byte starts on the edge that ends the previous gap or wait
  always_comb begin
    start   = 1'b0;
    tx_word = '0;
    case (state)
      S_RST_WAIT: begin
        tx_word = init_rom(idx);
        start   = wait_done;
      end
      S_INIT: begin
        tx_word = init_rom(idx);
        start   = (waiting && wait_done) ||
                  (eng_last && !wait_after && (idx != IDX_W'(8)));
      end
      S_IDLE: begin
        tx_word = win_rom(IDX_W'(0));
        start   = fill_req;
      end
      S_WIN: begin
        tx_word = (idx == IDX_W'(11)) ? {1'b1, color[15:8]} : win_rom(idx);
        start   = eng_last;
      end
      S_PIX: begin
        tx_word = pix_lo ? {1'b1, color[7:0]} : {1'b1, color[15:8]};
        start   = eng_last && (pix_lo || (pix_cnt != PIX_W'(PIX_TOT)));
      end
      default: begin
        start   = 1'b0;
        tx_word = '0;
      end
    endcase
  end

  // Byte engine: phases 0..15 alternate sclk low/high per bit, phase 16 is the cs-high gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_active <= 1'b0;
      phase      <= '0;
      div        <= '0;
      shreg      <= '0;
      lcd_sclk   <= 1'b0;
      lcd_mosi   <= 1'b0;
      lcd_cs     <= 1'b1;
      lcd_dc     <= 1'b0;
    end else if (start) begin
      eng_active <= 1'b1;
      phase      <= '0;
      div        <= '0;
      shreg      <= tx_word[7:0];
      lcd_sclk   <= 1'b0;
      lcd_mosi   <= tx_word[7];
      lcd_cs     <= 1'b0;
      lcd_dc     <= tx_word[8];
    end else if (eng_active) begin
      if (div != DIV_W'(CLK_DIV - 1)) begin
        div <= div + DIV_W'(1);
      end else begin
        div <= '0;
        if (phase == PH_W'(16)) begin
          eng_active <= 1'b0;
        end else begin
          phase <= phase + PH_W'(1);
          if (phase == PH_W'(15)) begin
            lcd_sclk <= 1'b0;
            lcd_cs   <= 1'b1;
          end else if (phase[0]) begin
            lcd_sclk <= 1'b0;
            lcd_mosi <= shreg[6];
            shreg    <= {shreg[6:0], 1'b0};
          end else begin
            lcd_sclk <= 1'b1;
          end
        end
      end
    end
  end

  // Sequencer FSM; idx always points at the next byte of the current list
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST_LOW;
      cnt       <= '0;
      idx       <= '0;
      waiting   <= 1'b0;
      color     <= '0;
      pix_cnt   <= '0;
      pix_lo    <= 1'b0;
      lcd_rst   <= 1'b0;
      lcd_blk   <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      fill_ack  <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_ack  <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        S_RST_LOW: begin
          if (cnt == CNT_W'(RST_LOW_CYC - 1)) begin
            cnt     <= '0;
            lcd_rst <= 1'b1;
            state   <= S_RST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RST_WAIT: begin
          if (wait_done) begin
            cnt   <= '0;
            idx   <= IDX_W'(1);
            state <= S_INIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_INIT: begin
          if (waiting) begin
            if (wait_done) begin
              waiting <= 1'b0;
              cnt     <= '0;
              idx     <= idx + IDX_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (eng_last) begin
            if (idx == IDX_W'(8)) begin
              init_done <= 1'b1;
              lcd_blk   <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else if (wait_after) begin
              waiting <= 1'b1;
              cnt     <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_IDLE: begin
          if (fill_req) begin
            fill_ack <= 1'b1;
            color    <= fill_color;
            busy     <= 1'b1;
            idx      <= IDX_W'(1);
            state    <= S_WIN;
          end
        end
        S_WIN: begin
          if (eng_last) begin
            if (idx == IDX_W'(11)) begin
              pix_cnt <= PIX_W'(1);
              pix_lo  <= 1'b1;
              state   <= S_PIX;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_PIX: begin
          if (eng_last) begin
            if (pix_lo) begin
              pix_lo <= 1'b0;
            end else if (pix_cnt == PIX_W'(PIX_TOT)) begin
              fill_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
              pix_lo  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Bench for lcd_fill_sequencer: decodes the SPI stream and compares it with the
// byte list expected from the panel protocol, with randomized colours and request timing.
`timescale 1ns/1ps
module tb_lcd_fill_sequencer;

  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned RST_LOW_CYC  = 10;
  localparam int unsigned RST_WAIT_CYC = 20;
  localparam int unsigned LCD_W        = 4;
  localparam int unsigned LCD_H        = 2;
  localparam int BYTE_CYC = 17 * CLK_DIV;
  localparam int CS_LOW   = 16 * CLK_DIV;
  localparam int GAP      = CLK_DIV;
  localparam int PIX_START = 11 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_req;
  logic [15:0] fill_color;
  logic        fill_ack, fill_done, busy, init_done;
  logic        lcd_sclk, lcd_mosi, lcd_cs, lcd_dc, lcd_rst, lcd_blk;

  lcd_fill_sequencer #(
    .CLK_DIV(CLK_DIV), .RST_LOW_CYC(RST_LOW_CYC), .RST_WAIT_CYC(RST_WAIT_CYC),
    .LCD_W(LCD_W), .LCD_H(LCD_H)
  ) dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .fill_color(fill_color),
    .fill_ack(fill_ack), .fill_done(fill_done), .busy(busy), .init_done(init_done),
    .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi), .lcd_cs(lcd_cs), .lcd_dc(lcd_dc),
    .lcd_rst(lcd_rst), .lcd_blk(lcd_blk)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] word;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0, done_cnt = 0;
  int exp_acks = 0, exp_dones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected {dc, byte} stream plus the cs-high gap before each byte (-1 = any)
  function automatic void push(input logic dc, input logic [7:0] b, input int gap);
    exp_t e;
    e.word = {dc, b};
    e.gap  = gap;
    exp_q.push_back(e);
  endfunction

  function automatic void model_init();
    push(1'b0, 8'h01, -1);
    push(1'b0, 8'h11, GAP + RST_WAIT_CYC);
    push(1'b0, 8'h3A, GAP + RST_WAIT_CYC);
    push(1'b1, 8'h55, GAP);
    push(1'b0, 8'h36, GAP);
    push(1'b1, 8'h00, GAP);
    push(1'b0, 8'h21, GAP);
    push(1'b0, 8'h29, GAP);
  endfunction

  function automatic void model_fill(input logic [15:0] c);
    int wm = LCD_W - 1;
    int hm = LCD_H - 1;
    push(1'b0, 8'h2A, -1);
    push(1'b1, 8'h00, GAP);
    push(1'b1, 8'h00, GAP);
    push(1'b1, 8'(wm / 256), GAP);
    push(1'b1, 8'(wm % 256), GAP);
    push(1'b0, 8'h2B, GAP);
    push(1'b1, 8'h00, GAP);
    push(1'b1, 8'h00, GAP);
    push(1'b1, 8'(hm / 256), GAP);
    push(1'b1, 8'(hm % 256), GAP);
    push(1'b0, 8'h2C, GAP);
    for (int p = 0; p < LCD_W * LCD_H; p++) begin
      push(1'b1, c[15:8], GAP);
      push(1'b1, c[7:0], GAP);
    end
  endfunction

  // SPI decoder: bits captured on sclk rising edges, timing measured in clk cycles
  logic prev_sclk, prev_mosi, prev_cs, prev_ack;
  int   bit_n, low_len, hi_len, cur_gap;
  logic [7:0] sh;

  always @(negedge clk) begin
    if (rst) begin
      prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1; prev_ack = 1'b0;
      bit_n = 0; low_len = 0; hi_len = 0; cur_gap = 0; sh = '0;
    end else begin
      if (lcd_cs && !prev_cs) check("cs_low_len", low_len, CS_LOW);
      if (!lcd_cs && prev_cs) begin
        cur_gap = hi_len;
        bit_n   = 0;
      end
      if (lcd_cs) begin
        hi_len++;
        low_len = 0;
      end else begin
        low_len++;
        hi_len = 0;
      end
      if (lcd_sclk && !prev_sclk) begin
        check("mosi_stable", lcd_mosi, prev_mosi);
        check("cs_at_sclk", lcd_cs, 1'b0);
        sh = {sh[6:0], lcd_mosi};
        bit_n++;
        if (bit_n == 8) begin
          check("exp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("byte", {lcd_dc, sh}, e.word);
            if (e.gap >= 0) check("gap", cur_gap, e.gap);
          end
          bit_n = 0;
        end
      end
      if (fill_ack) begin
        ack_cnt++;
        check("ack_width", prev_ack, 1'b0);
      end
      if (fill_done) begin
        done_cnt++;
        check("ack_done_excl", fill_ack, 1'b0);
      end
      prev_sclk = lcd_sclk;
      prev_mosi = lcd_mosi;
      prev_cs   = lcd_cs;
      prev_ack  = fill_ack;
    end
  end

  task automatic run_init(input bit pulse_req);
    int n;
    model_init();
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_rst) break;
      n++;
    end
    check("rst_low_cycles", n, RST_LOW_CYC);
    if (pulse_req) begin
      repeat ($urandom_range(40, 200)) @(negedge clk);
      fill_color = 16'($urandom);
      fill_req = 1'b1;
      repeat (3) @(negedge clk);
      fill_req = 1'b0;
      check("busy_in_init", {busy, init_done}, 2'b10);
    end
    for (int i = 0; i < 2000; i++) begin
      if (init_done) break;
      @(negedge clk);
    end
    check("init_done", init_done, 1'b1);
    check("idle_flags", {lcd_blk, busy, lcd_cs, lcd_sclk}, 4'b1010);
    check("init_bytes_left", exp_q.size(), 0);
    check("ack_count_init", ack_cnt, exp_acks);
  endtask

  task automatic start_fill(input logic [15:0] c);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_before_fill", busy, 1'b0);
    fill_color = c;
    fill_req   = 1'b1;
    model_fill(c);
    exp_acks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fill_ack) break;
    end
    check("ack_seen", fill_ack, 1'b1);
    check("busy_at_ack", busy, 1'b1);
    fill_req = 1'b0;
  endtask

  task automatic mid_pix(input logic [15:0] c, input bit pulse_req);
    repeat (PIX_START + $urandom_range(10, 300)) @(negedge clk);
    fill_color = c;
    if (pulse_req) begin
      fill_req = 1'b1;
      repeat (2) @(negedge clk);
      fill_req = 1'b0;
    end
  endtask

  task automatic finish_fill();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fill_done) break;
    end
    exp_dones++;
    check("fill_done", fill_done, 1'b1);
    check("busy_at_done", busy, 1'b1);
    check("fill_bytes_left", exp_q.size(), 0);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("ack_count", ack_cnt, exp_acks);
    check("done_count", done_cnt, exp_dones);
  endtask

  initial begin
    logic [15:0] ca, cb;
    rst = 1'b1;
    fill_req = 1'b0;
    fill_color = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {lcd_sclk, lcd_mosi, lcd_cs, lcd_dc, lcd_rst, lcd_blk, busy, init_done, fill_ack, fill_done},
          10'b0010001000);

    run_init(1'b1);

    start_fill(16'hF800);
    mid_pix(16'h07E0, 1'b1);
    finish_fill();

    for (int k = 0; k < 2; k++) begin
      start_fill(16'($urandom));
      mid_pix(16'($urandom), k == 0);
      finish_fill();
    end

    // Request held high through a fill is taken on the first idle cycle
    ca = 16'($urandom);
    cb = 16'($urandom);
    start_fill(ca);
    @(negedge clk);
    fill_req = 1'b1;
    fill_color = cb;
    finish_fill();
    model_fill(cb);
    exp_acks++;
    @(negedge clk);
    check("b2b_ack", fill_ack, 1'b1);
    fill_req = 1'b0;
    mid_pix(16'($urandom), 1'b0);
    finish_fill();

    // Asynchronous reset while a pixel bit is on the wire
    start_fill(16'($urandom));
    repeat (PIX_START + $urandom_range(10, 300)) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (lcd_sclk) break;
      @(negedge clk);
    end
    check("pre_rst_sclk", {lcd_sclk, lcd_cs}, 2'b10);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_outputs",
          {lcd_cs, lcd_sclk, lcd_rst, init_done, busy, lcd_blk, fill_ack, fill_done},
          8'b10001000);
    exp_q.delete();
    repeat (3) @(negedge clk);
    run_init(1'b0);
    start_fill(16'($urandom));
    finish_fill();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
